park_iter: RTL and testbench



---
 rtl/foc_pkg.sv | 43 ++++
 rtl/cordic_quadrant_fold.sv | 41 ++++
 rtl/park_iter.sv | 160 ++++++++++++++++
 tb/tb_park_iter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/foc_pkg.sv
// rtl/foc_pkg.sv - shared constants, CORDIC tables, FSM states and helpers for the FOC datapath
package foc_pkg;

    // Angle constants below are tabulated at this many fractional bits.
    localparam int ANGLE_FRAC  = 8;
    localparam int PI          = 804;
    localparam int PI_2        = 402;
    localparam int K_INV       = 39797;
    localparam int K_INV_SHIFT = 16;

    localparam int CORDIC_ATAN [16] = '{201, 119, 63, 32, 16, 8, 4, 2, 1, 0, 0, 0, 0, 0, 0, 0};

    typedef enum logic [2:0] {
        IDLE,
        FOLD,
        ROTATE,
        SCALE,
        DONE
    } foc_state_e;

    // Rescale an ANGLE_FRAC angle constant to another fixed-point format (exact at ANGLE_FRAC).
    function automatic int scale_angle(input int v, input int frac);
        if (frac >= ANGLE_FRAC) begin
            return v <<< (frac - ANGLE_FRAC);
        end
        return (v + (1 <<< (ANGLE_FRAC - frac - 1))) >>> (ANGLE_FRAC - frac);
    endfunction

    function automatic logic signed [31:0] sat_to_width(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// rtl/cordic_quadrant_fold.sv - combinational +/-90 degree pre-rotation bringing the angle into CORDIC range
module cordic_quadrant_fold #(
    parameter int WIDTH      = 12,
    parameter int PI_2_ANGLE = 402
) (
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] y_i,
    input  logic signed [WIDTH-1:0] angle_i,
    output logic signed [WIDTH+1:0] x_o,
    output logic signed [WIDTH+1:0] y_o,
    output logic signed [WIDTH:0]   z_o
);
    localparam int XW = WIDTH + 2;
    localparam int ZW = WIDTH + 1;
    localparam logic signed [ZW-1:0] PI_2_Z = ZW'(PI_2_ANGLE);

    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] ye;
    logic signed [ZW-1:0] ae;

    assign xe = XW'(x_i);
    assign ye = XW'(y_i);
    assign ae = ZW'(angle_i);

    // Rotating by -angle: a -90 degree step maps (x, y) to (y, -x), a +90 degree step to (-y, x).
    always_comb begin
        x_o = xe;
        y_o = ye;
        z_o = ae;
        if (ae > PI_2_Z) begin
            x_o = ye;
            y_o = -xe;
            z_o = ae - PI_2_Z;
        end else if (ae < -PI_2_Z) begin
            x_o = -ye;
            y_o = xe;
            z_o = ae + PI_2_Z;
        end
    end

endmodule

// File: rtl/park_iter.sv
// rtl/park_iter.sv - iterative CORDIC forward Park transform: (alpha, beta) rotated by -angle into (d, q)
module park_iter
    import foc_pkg::*;
#(
    parameter int WIDTH           = 12,
    parameter int FRACTIONAL_BITS = 8,
    parameter int ITERATIONS      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] alpha,
    input  logic signed [WIDTH-1:0] beta,
    input  logic signed [WIDTH-1:0] angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] d,
    output logic signed [WIDTH-1:0] q
);
    localparam int XW     = WIDTH + 2;
    localparam int ZW     = WIDTH + 1;
    localparam int PI_2_S = scale_angle(PI_2, FRACTIONAL_BITS);

    foc_state_e state_q, state_d;
    logic [3:0] iter_q, iter_d;

    logic signed [WIDTH-1:0] alpha_q, alpha_d;
    logic signed [WIDTH-1:0] beta_q, beta_d;
    logic signed [WIDTH-1:0] angle_q, angle_d;
    logic signed [XW-1:0]    x_q, x_d;
    logic signed [XW-1:0]    y_q, y_d;
    logic signed [ZW-1:0]    z_q, z_d;
    logic signed [WIDTH-1:0] d_out_q, d_out_d;
    logic signed [WIDTH-1:0] q_out_q, q_out_d;

    logic signed [XW-1:0] fold_x;
    logic signed [XW-1:0] fold_y;
    logic signed [ZW-1:0] fold_z;
    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;
    logic signed [ZW-1:0] atan_z;
    logic signed [31:0]   prod_x;
    logic signed [31:0]   prod_y;
    logic signed [31:0]   rnd_x;
    logic signed [31:0]   rnd_y;

    cordic_quadrant_fold #(
        .WIDTH      (WIDTH),
        .PI_2_ANGLE (PI_2_S)
    ) u_fold (
        .x_i     (alpha_q),
        .y_i     (beta_q),
        .angle_i (angle_q),
        .x_o     (fold_x),
        .y_o     (fold_y),
        .z_o     (fold_z)
    );

    assign x_sh   = x_q >>> iter_q;
    assign y_sh   = y_q >>> iter_q;
    assign atan_z = ZW'(scale_angle(CORDIC_ATAN[iter_q], FRACTIONAL_BITS));

    // Gain compensation with round-half-up before the final shift.
    assign prod_x = 32'(x_q) * K_INV;
    assign prod_y = 32'(y_q) * K_INV;
    assign rnd_x  = (prod_x + (32'sd1 <<< (K_INV_SHIFT - 1))) >>> K_INV_SHIFT;
    assign rnd_y  = (prod_y + (32'sd1 <<< (K_INV_SHIFT - 1))) >>> K_INV_SHIFT;

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        alpha_d   = alpha_q;
        beta_d    = beta_q;
        angle_d   = angle_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        d_out_d   = d_out_q;
        q_out_d   = q_out_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    alpha_d = alpha;
                    beta_d  = beta;
                    angle_d = angle;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                x_d     = fold_x;
                y_d     = fold_y;
                z_d     = fold_z;
                iter_d  = 4'd0;
                state_d = ROTATE;
            end
            ROTATE: begin
                // Drive z toward zero; each step rotates (x, y) by -sigma*atan(2^-i).
                if (z_q[ZW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q + atan_z;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q - atan_z;
                end
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITERATIONS - 1)) begin
                    state_d = SCALE;
                end
            end
            SCALE: begin
                d_out_d = WIDTH'(sat_to_width(rnd_x, WIDTH));
                q_out_d = WIDTH'(sat_to_width(rnd_y, WIDTH));
                state_d = DONE;
            end
            DONE: begin
                out_valid = !rst;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            alpha_q <= '0;
            beta_q  <= '0;
            angle_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            d_out_q <= '0;
            q_out_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            alpha_q <= alpha_d;
            beta_q  <= beta_d;
            angle_q <= angle_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            d_out_q <= d_out_d;
            q_out_q <= q_out_d;
        end
    end

    assign d = d_out_q;
    assign q = q_out_q;

endmodule

// File: tb/tb_park_iter.sv
// tb/tb_park_iter.sv - scoreboard bench for park_iter against a trigonometric reference model
module tb_park_iter;
    localparam int W       = 12;
    localparam int TOL     = 3;
    localparam int LATENCY = 12;
    localparam int MAXV    = 2047;
    localparam int MINV    = -2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready;
    logic out_valid;
    logic signed [W-1:0] alpha = '0;
    logic signed [W-1:0] beta = '0;
    logic signed [W-1:0] angle = '0;
    logic signed [W-1:0] d;
    logic signed [W-1:0] q;

    park_iter #(
        .WIDTH           (W),
        .FRACTIONAL_BITS (8),
        .ITERATIONS      (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alpha     (alpha),
        .beta      (beta),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .q         (q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ed;
        int eq;
        int acc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic bit saturating(input int v);
        return (v > MAXV + TOL) || (v < MINV - TOL);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: d + jq = (alpha + j*beta) * exp(-j*theta), theta = angle / 2^8 rad.
    task automatic send(input int a, input int b, input int ang);
        int n;
        real th;
        real dr;
        real qr;
        exp_t e;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_timeout", in_ready, int'(in_ready), 1);
        if (in_ready) begin
            alpha    = W'(a);
            beta     = W'(b);
            angle    = W'(ang);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            th    = real'(ang) / 256.0;
            dr    = real'(a) * $cos(th) + real'(b) * $sin(th);
            qr    = -real'(a) * $sin(th) + real'(b) * $cos(th);
            e.ed  = int'(dr);
            e.eq  = int'(qr);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size() == 0, exp_q.size(), 0);
    endtask

    // Monitor: latency on each rising out_valid, values on each handshake.
    initial begin : monitor
        bit prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    if (exp_q.size() > 0)
                        check("latency", (cyc - exp_q[0].acc) == LATENCY, cyc - exp_q[0].acc, LATENCY);
                    else
                        check("unexpected_out_valid", 1'b0, 1, 0);
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    // Accuracy is only promised for samples with no saturated output.
                    if (saturating(e.ed))
                        check("d_sat", int'(d) == clamp(e.ed), int'(d), clamp(e.ed));
                    else if (!saturating(e.eq))
                        check("d_val", iabs(int'(d) - clamp(e.ed)) <= TOL, int'(d), clamp(e.ed));
                    if (saturating(e.eq))
                        check("q_sat", int'(q) == clamp(e.eq), int'(q), clamp(e.eq));
                    else if (!saturating(e.ed))
                        check("q_val", iabs(int'(q) - clamp(e.eq)) <= TOL, int'(q), clamp(e.eq));
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin : rand_backpressure
        forever begin
            @(posedge clk);
            #2;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : stimulus
        int d0;
        int q0;
        int a;
        int b;
        int ang;
        int n;

        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", !in_ready, int'(in_ready), 0);
        check("rst_out_valid", !out_valid, int'(out_valid), 0);
        check("rst_d", d == 0, int'(d), 0);
        check("rst_q", q == 0, int'(q), 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, int'(in_ready), 1);

        // Directed: axes, fold boundaries, both fold branches, saturation.
        send(256, 0, 0);
        send(256, 0, 402);
        send(0, 256, 402);
        send(256, 0, 804);
        send(256, 0, -804);
        send(256, 0, 403);
        send(-150, 120, -403);
        send(2047, 2047, 201);
        send(-2048, -2048, 201);
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            a   = int'($urandom_range(0, 128)) - 64;
            b   = int'($urandom_range(0, 128)) - 64;
            ang = int'($urandom_range(0, 1608)) - 804;
            send(a, b, ang);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        // Backpressure: result held while out_ready is low; busy-time in_valid ignored.
        out_ready = 1'b0;
        send(300, -200, 100);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("bp_out_valid", out_valid, int'(out_valid), 1);
        d0 = int'(d);
        q0 = int'(q);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                alpha    = W'(1000);
                beta     = W'(1000);
                angle    = W'(500);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            check("bp_hold_valid", out_valid && !in_ready, int'(out_valid), 1);
            check("bp_hold_d", int'(d) == d0, int'(d), d0);
            check("bp_hold_q", int'(q) == q0, int'(q), q0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, int'(in_ready), 1);
        check("bp_release_out_valid", !out_valid, int'(out_valid), 0);

        // Reset while rotating at i=5 aborts the sample.
        send(256, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst = 1'b0;
        #1;
        check("abort_out_valid", !out_valid, int'(out_valid), 0);
        check("abort_d", d == 0, int'(d), 0);
        check("abort_q", q == 0, int'(q), 0);
        check("abort_in_ready", in_ready, int'(in_ready), 1);
        send(100, 50, -300);
        send(-200, 0, 600);
        drain();

        for (int i = 0; i < 5; i++) tick();
        check("no_extra_output", !out_valid, int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
